// File: rtl/axi_cmd_master_pkg.sv
// Shared types, AXI4 constants and the 4 KiB page check for axi_cmd_master.
// The AXI structs below are the default req_t/resp_t of the initiator.
package axi_cmd_master_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_resp_t;

  // True when a burst starting at this page offset runs past the 4 KiB page end.
  function automatic logic crosses_4k(input logic [11:0] offset,
                                      input logic [8:0]  beats,
                                      input int unsigned beat_bytes);
    logic [31:0] end_byte;
    end_byte = {20'd0, offset} + ({23'd0, beats} * beat_bytes);
    return end_byte > 32'd4096;
  endfunction

endpackage

// File: rtl/axi_cmd_master.sv
// Command/stream to AXI4 INCR-burst initiator, one outstanding transaction.
// Optional response watchdog: define AXI_CMD_MASTER_TIMEOUT_EN.
module axi_cmd_master
  import axi_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter type         req_t          = axi_req_t,
  parameter type         resp_t         = axi_resp_t
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [7:0]              cmd_len_i,
  input  logic                    wdata_valid_i,
  output logic                    wdata_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    rdata_valid_o,
  input  logic                    rdata_ready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rdata_last_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    timeout_o,
  output logic                    busy_o,
  output req_t                    axi_req_o,
  input  resp_t                   axi_resp_i
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [2:0]  AX_SIZE    = 3'($clog2(BEAT_BYTES));

  state_e                state_r;
  state_e                state_d;
  logic                  cmd_ready_r;
  logic                  write_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            len_r;
  logic [7:0]            beat_cnt_r;
  logic                  err_r;

  logic       accept_s;
  logic [8:0] beats_s;
  logic       reject_s;
  logic       final_beat_s;
  logic       timeout_hit_s;
  logic       w_hs_s;
  logic       b_hs_s;
  logic       r_hs_s;
  logic       b_ok_s;
  logic       err_set_s;
  logic       beat_inc_s;
  logic       unused_s;

  assign accept_s     = cmd_valid_i & cmd_ready_r;
  assign beats_s      = {1'b0, len_r} + 9'd1;
  assign reject_s     = (32'(beats_s) > MAX_LEN) |
                        crosses_4k(addr_r[11:0], beats_s, BEAT_BYTES);
  assign final_beat_s = (beat_cnt_r == len_r);

  assign w_hs_s = (state_r == ST_WR_DATA) & wdata_valid_i & axi_resp_i.w_ready;
  assign b_hs_s = (state_r == ST_WR_RESP) & ~timeout_hit_s & axi_resp_i.b_valid;
  assign r_hs_s = (state_r == ST_RD_DATA) & ~timeout_hit_s & rdata_ready_i &
                  axi_resp_i.r_valid;
  assign b_ok_s = (axi_resp_i.b.resp == RESP_OKAY) |
                  (axi_resp_i.b.resp == RESP_EXOKAY);

  assign unused_s = ^{axi_resp_i.b.id, axi_resp_i.r.id};

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
  logic [31:0] wd_cnt_r;
  logic        wd_run_s;
  logic        timeout_r;

  assign wd_run_s      = (state_r == ST_WR_RESP) | (state_r == ST_RD_DATA);
  assign timeout_hit_s = wd_run_s & ((wd_cnt_r + 32'd1) >= 32'(TIMEOUT_CYCLES));
  assign timeout_o     = (state_r == ST_DONE) & timeout_r;

  // Response watchdog: counts idle response cycles, restarts on each B/R handshake.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wd_cnt_r  <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      if (!wd_run_s || b_hs_s || r_hs_s) begin
        wd_cnt_r <= 32'd0;
      end else begin
        wd_cnt_r <= wd_cnt_r + 32'd1;
      end
      if (accept_s) begin
        timeout_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo_s;

  assign timeout_hit_s = 1'b0;
  assign timeout_o     = 1'b0;
  assign unused_tmo_s  = ^(32'(TIMEOUT_CYCLES));
`endif

  // Next-state decode plus error/beat-counter update requests.
  always_comb begin
    state_d    = state_r;
    err_set_s  = 1'b0;
    beat_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (reject_s) begin
          state_d   = ST_DONE;
          err_set_s = 1'b1;
        end else if (write_r) begin
          state_d = ST_WR_ADDR;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if (axi_resp_i.aw_ready) begin
          state_d = ST_WR_DATA;
        end else begin
          state_d = ST_WR_ADDR;
        end
      end
      ST_WR_DATA: begin
        if (w_hs_s && final_beat_s) begin
          state_d = ST_WR_RESP;
        end else if (w_hs_s) begin
          beat_inc_s = 1'b1;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (timeout_hit_s) begin
          state_d   = ST_DONE;
          err_set_s = 1'b1;
        end else if (b_hs_s) begin
          state_d   = ST_DONE;
          err_set_s = ~b_ok_s;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (axi_resp_i.ar_ready) begin
          state_d = ST_RD_DATA;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (timeout_hit_s) begin
          state_d   = ST_DONE;
          err_set_s = 1'b1;
        end else if (r_hs_s) begin
          // A misplaced or missing r.last is an error; the burst ends either way.
          err_set_s = (axi_resp_i.r.resp != RESP_OKAY) |
                      (axi_resp_i.r.last != final_beat_s);
          if (final_beat_s || axi_resp_i.r.last) begin
            state_d = ST_DONE;
          end else begin
            beat_inc_s = 1'b1;
          end
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake-ready and sticky error registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      beat_cnt_r  <= 8'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_d;
      cmd_ready_r <= (state_d == ST_IDLE);
      if (accept_s) begin
        beat_cnt_r <= 8'd0;
        err_r      <= 1'b0;
      end else begin
        if (beat_inc_s) begin
          beat_cnt_r <= beat_cnt_r + 8'd1;
        end
        if (err_set_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  // Command capture; fields stay stable for the whole transaction.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      write_r <= 1'b0;
      addr_r  <= '0;
      len_r   <= 8'd0;
    end else if (accept_s) begin
      write_r <= cmd_write_i;
      addr_r  <= cmd_addr_i;
      len_r   <= cmd_len_i;
    end
  end

  // AXI request assembly from registered command fields and state.
  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = AXI_ID_W'(AXI_ID);
    axi_req_o.aw.addr   = AXI_ADDR_W'(addr_r);
    axi_req_o.aw.len    = len_r;
    axi_req_o.aw.size   = AX_SIZE;
    axi_req_o.aw.burst  = BURST_INCR;
    axi_req_o.aw.lock   = 1'b0;
    axi_req_o.aw.cache  = 4'd0;
    axi_req_o.aw.prot   = 3'd0;
    axi_req_o.aw.qos    = 4'd0;
    axi_req_o.aw.region = 4'd0;
    axi_req_o.ar        = axi_req_o.aw;
    axi_req_o.aw_valid  = (state_r == ST_WR_ADDR);
    axi_req_o.ar_valid  = (state_r == ST_RD_ADDR);
    axi_req_o.w.data    = AXI_DATA_W'(wdata_i);
    axi_req_o.w.strb    = AXI_STRB_W'(wstrb_i);
    axi_req_o.w.last    = final_beat_s;
    axi_req_o.w_valid   = (state_r == ST_WR_DATA) & wdata_valid_i;
    axi_req_o.b_ready   = (state_r == ST_WR_RESP) & ~timeout_hit_s;
    axi_req_o.r_ready   = (state_r == ST_RD_DATA) & ~timeout_hit_s & rdata_ready_i;
  end

  assign cmd_ready_o   = cmd_ready_r;
  assign wdata_ready_o = (state_r == ST_WR_DATA) & axi_resp_i.w_ready;
  assign rdata_valid_o = (state_r == ST_RD_DATA) & ~timeout_hit_s & axi_resp_i.r_valid;
  assign rdata_o       = DATA_WIDTH'(axi_resp_i.r.data);
  assign rdata_last_o  = (state_r == ST_RD_DATA) & final_beat_s;
  assign done_o        = (state_r == ST_DONE);
  assign err_o         = (state_r == ST_DONE) & err_r;
  assign busy_o        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_axi_cmd_master.sv
// Table-driven bench for axi_cmd_master: the bench plays both the command
// source and the AXI slave, cycle by cycle, against hand-computed expectations.
module tb_axi_cmd_master;
  import axi_cmd_master_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        arst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [63:0] rdata;
  logic        done, err, timeout, busy;
  axi_req_t    axi_req;
  axi_resp_t   axi_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_cmd_master #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .AXI_ID(0), .MAX_LEN(16),
    .TIMEOUT_CYCLES(TMO), .req_t(axi_req_t), .resp_t(axi_resp_t)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .wdata_i(wdata), .wstrb_i(wstrb),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
    .rdata_o(rdata), .rdata_last_o(rdata_last),
    .done_o(done), .err_o(err), .timeout_o(timeout), .busy_o(busy),
    .axi_req_o(axi_req), .axi_resp_i(axi_resp)
  );

  typedef struct {
    bit          write;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [63:0] dbase;
    logic [1:0]  resp;
    int          rlast_mode;  // 0 normal, 1 early r.last at rlast_at, 2 never
    int          rlast_at;
    int          stall_at;
    int          stall_len;
    int          b_delay;
    bit          exp_reject;
    bit          exp_err;
    bit          exp_timeout;
    int          exp_beats;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic [63:0] a, logic [7:0] l, logic [63:0] d,
                              logic [1:0] rs, int rm, int ra, int sa, int sl, int bd,
                              bit rj, bit e, bit t, int nb);
    vec_t v;
    v.write = w; v.addr = a; v.len = l; v.dbase = d; v.resp = rs;
    v.rlast_mode = rm; v.rlast_at = ra; v.stall_at = sa; v.stall_len = sl;
    v.b_delay = bd; v.exp_reject = rj; v.exp_err = e; v.exp_timeout = t;
    v.exp_beats = nb;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, beat = 0, bwait = 0, phase = 0;  // 0 addr, 1 W, 2 B, 3 R, 4 over
    int addr_cnt = 0, wrong_cnt = 0, end_cyc = -1, w_last_cyc = -1, done_cyc = -1;
    int exp_done;
    axi_ax_chan_t ax;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk($sformatf("v%0d_cmd_ready", idx), 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      axi_resp = '0;
      axi_resp.aw_ready = 1'b1; axi_resp.ar_ready = 1'b1; axi_resp.w_ready = 1'b1;
      wdata_valid = (phase == 1);
      wdata = v.dbase * 64'(beat + 1);
      wstrb = 8'hFF;
      rdata_ready = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      if (phase == 2) begin
        axi_resp.b_valid = (bwait >= v.b_delay);
        axi_resp.b.resp  = v.resp;
      end
      if (phase == 3) begin
        axi_resp.r_valid = 1'b1;
        axi_resp.r.data  = v.dbase + 64'(beat);
        axi_resp.r.resp  = v.resp;
        axi_resp.r.last  = (v.rlast_mode == 0) ? (beat == int'(v.len)) :
                           (v.rlast_mode == 1) ? (beat == v.rlast_at) : 1'b0;
      end
      #1;
      if (cyc == 1) chk($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
      if (axi_req.aw_valid || axi_req.ar_valid) begin
        addr_cnt++;
        if (axi_req.aw_valid != v.write || axi_req.ar_valid == v.write) wrong_cnt++;
        if (addr_cnt == 1) begin
          ax = v.write ? axi_req.aw : axi_req.ar;
          chk($sformatf("v%0d_addr_latency", idx), 64'(cyc), 64'd2);
          chk($sformatf("v%0d_ax_addr", idx), ax.addr, v.addr);
          chk($sformatf("v%0d_ax_len_size_burst", idx), 64'({ax.len, ax.size, ax.burst}),
              64'({v.len, 3'd3, 2'd1}));
        end
        phase = v.write ? 1 : 3;
      end else if (phase == 1 && wdata_ready) begin
        chk($sformatf("v%0d_w_valid", idx), 64'(axi_req.w_valid), 64'd1);
        chk($sformatf("v%0d_w_data", idx), axi_req.w.data, v.dbase * 64'(beat + 1));
        chk($sformatf("v%0d_w_strb_last", idx), 64'({axi_req.w.strb, axi_req.w.last}),
            64'({8'hFF, beat == int'(v.len)}));
        if (beat == int'(v.len)) begin
          phase = 2;
          w_last_cyc = cyc;
        end
        beat++;
      end else if (phase == 2) begin
        if (axi_resp.b_valid && axi_req.b_ready) begin
          phase = 4;
          end_cyc = cyc;
        end else begin
          bwait++;
        end
      end else if (phase == 3) begin
        chk($sformatf("v%0d_r_ready", idx), 64'(axi_req.r_ready), 64'(rdata_ready));
        if (axi_req.r_ready) begin
          chk($sformatf("v%0d_rdata", idx), rdata, v.dbase + 64'(beat));
          chk($sformatf("v%0d_rvalid_rlast", idx), 64'({rdata_valid, rdata_last}),
              64'({1'b1, beat == int'(v.len)}));
          if (beat == int'(v.len) || axi_resp.r.last) begin
            phase = 4;
            end_cyc = cyc;
          end
          beat++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
        chk($sformatf("v%0d_timeout", idx), 64'(timeout), 64'(v.exp_timeout));
        chk($sformatf("v%0d_ready_in_done", idx), 64'(cmd_ready), 64'd0);
      end
    end
    if (done_cyc < 0) begin
      chk($sformatf("v%0d_done_seen", idx), 64'd0, 64'd1);
    end else begin
      if (v.exp_reject) exp_done = 2;
      else if (v.exp_timeout) exp_done = w_last_cyc + 1 + int'(TMO);
      else exp_done = end_cyc + 1;
      chk($sformatf("v%0d_done_cycle", idx), 64'(done_cyc), 64'(exp_done));
    end
    chk($sformatf("v%0d_addr_count", idx), 64'(addr_cnt), v.exp_reject ? 64'd0 : 64'd1);
    chk($sformatf("v%0d_wrong_channel", idx), 64'(wrong_cnt), 64'd0);
    chk($sformatf("v%0d_beats", idx), 64'(beat), 64'(v.exp_beats));
    axi_resp = '0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 64'd0; cmd_len = 8'd0;
    wdata_valid = 1'b0; wdata = 64'd0; wstrb = 8'd0; rdata_ready = 1'b0;
    axi_resp = '0;

    //       w     addr        len    dbase        resp         rm ra sa sl bd  rj e  t  beats
    tbl[0]  = mk(1, 64'h1000, 8'd3,   64'h11,   RESP_OKAY,   0, 0, 0, 0, 0,  0, 0, 0, 4);
    tbl[1]  = mk(0, 64'h2008, 8'd0,   64'hDEAD, RESP_SLVERR, 0, 0, 0, 0, 0,  0, 1, 0, 1);
    tbl[2]  = mk(1, 64'h1000, 8'hFF,  64'h1,    RESP_OKAY,   0, 0, 0, 0, 0,  1, 1, 0, 0);
    tbl[3]  = mk(0, 64'h0FF8, 8'd1,   64'h1,    RESP_OKAY,   0, 0, 0, 0, 0,  1, 1, 0, 0);
    tbl[4]  = mk(1, 64'h0FF8, 8'd1,   64'h1,    RESP_OKAY,   0, 0, 0, 0, 0,  1, 1, 0, 0);
    tbl[5]  = mk(0, 64'h3000, 8'd7,   64'h100,  RESP_OKAY,   0, 0, 5, 3, 0,  0, 0, 0, 8);
    tbl[6]  = mk(1, 64'h0F80, 8'd15,  64'h1,    RESP_OKAY,   0, 0, 0, 0, 0,  0, 0, 0, 16);
    tbl[7]  = mk(0, 64'h5000, 8'd16,  64'h1,    RESP_OKAY,   0, 0, 0, 0, 0,  1, 1, 0, 0);
    tbl[8]  = mk(1, 64'h6000, 8'd1,   64'h5,    RESP_DECERR, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    tbl[9]  = mk(1, 64'h6100, 8'd0,   64'h7,    RESP_EXOKAY, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    tbl[10] = mk(0, 64'h7000, 8'd1,   64'h70,   RESP_EXOKAY, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    tbl[11] = mk(0, 64'h8000, 8'd3,   64'h80,   RESP_OKAY,   1, 1, 0, 0, 0,  0, 1, 0, 2);
    tbl[12] = mk(0, 64'h9000, 8'd2,   64'h90,   RESP_OKAY,   2, 0, 0, 0, 0,  0, 1, 0, 3);
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    tbl[13] = mk(1, 64'hA000, 8'd0,   64'hA0,   RESP_OKAY,   0, 0, 0, 0, 40, 0, 1, 1, 1);
`else
    tbl[13] = mk(1, 64'hA000, 8'd0,   64'hA0,   RESP_OKAY,   0, 0, 0, 0, 40, 0, 0, 0, 1);
`endif

    #12;
    chk("reset_outputs", 64'({cmd_ready, busy, done, err, timeout}), 64'd0);
    chk("reset_axi_valids", 64'({axi_req.aw_valid, axi_req.ar_valid, axi_req.w_valid,
                                 axi_req.b_ready, axi_req.r_ready}), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

    // Reset while the read address is being presented.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h4000; cmd_len = 8'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("midrst_ar_before", 64'(axi_req.ar_valid), 64'd1);
    #2 arst = 1'b1;
    #1 chk("midrst_dropped", 64'({axi_req.ar_valid, busy, cmd_ready}), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1 chk("midrst_ready", 64'(cmd_ready), 64'd1);
    run_vec(100, tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
